// File: rtl/sd_frame_muxer.sv
// Transmit-side frame assembler: header, optional CRC16, side info and main data
// are serialised into one registered valid/ready byte stream.
module sd_frame_muxer #(
  parameter int SIDE_MONO   = 17,
  parameter int SIDE_STEREO = 32,
  parameter int FS_W        = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hdr_iv,
  output logic            hdr_ready,
  input  logic [31:0]     hdr_word,
  input  logic [15:0]     crc_word,
  input  logic            prot,
  input  logic [1:0]      mode,
  input  logic [FS_W-1:0] frame_size,
  input  logic [7:0]      si_din,
  input  logic            si_iv,
  output logic            si_ready,
  input  logic [7:0]      md_din,
  input  logic            md_iv,
  output logic            md_ready,
  output logic [7:0]      d_out,
  output logic            d_ov,
  input  logic            d_ready,
  output logic [FS_W-1:0] byte_counter,
  output logic            busy,
  output logic            frame_done,
  output logic            size_err
);

  typedef enum logic [2:0] {IDLE, HDR, CRC, SIDE, MAIN, DRAIN} state_t;

  state_t          state, state_nx;
  logic [FS_W-1:0] cnt, cnt_nx;
  logic [23:0]     hdr_r;
  logic [15:0]     crc_r;
  logic            prot_r;
  logic [FS_W-1:0] side_len_r, main_len_r;
  logic [FS_W-1:0] side_len_in, ovh_in;
  logic            can_load, hs, load, accept, reject, done;
  logic [7:0]      load_byte;

  assign can_load  = !d_ov || d_ready;
  assign hs        = d_ov && d_ready;
  assign hdr_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign si_ready  = (state == SIDE) && can_load;
  assign md_ready  = (state == MAIN) && can_load;

  always_comb begin
    side_len_in = (mode == 2'b11) ? FS_W'(SIDE_MONO) : FS_W'(SIDE_STEREO);
    ovh_in      = side_len_in + (prot ? FS_W'(4) : FS_W'(6));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The first header byte is loaded on the accepting edge; DRAIN keeps the
  // block busy until the last loaded byte has actually been handed off.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load      = 1'b0;
    load_byte = '0;
    accept    = 1'b0;
    reject    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (hdr_iv) begin
          if (frame_size < ovh_in) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            load      = 1'b1;
            load_byte = hdr_word[31:24];
            state_nx  = HDR;
            cnt_nx    = FS_W'(3);
          end
        end
      end
      HDR: begin
        if (can_load) begin
          load = 1'b1;
          case (cnt[1:0])
            2'd3:    load_byte = hdr_r[23:16];
            2'd2:    load_byte = hdr_r[15:8];
            default: load_byte = hdr_r[7:0];
          endcase
          if (cnt == FS_W'(1)) begin
            if (prot_r) begin
              state_nx = SIDE;
              cnt_nx   = side_len_r;
            end else begin
              state_nx = CRC;
              cnt_nx   = FS_W'(2);
            end
          end else begin
            cnt_nx = cnt - FS_W'(1);
          end
        end
      end
      CRC: begin
        if (can_load) begin
          load      = 1'b1;
          load_byte = cnt[1] ? crc_r[15:8] : crc_r[7:0];
          if (cnt == FS_W'(1)) begin
            state_nx = SIDE;
            cnt_nx   = side_len_r;
          end else begin
            cnt_nx = cnt - FS_W'(1);
          end
        end
      end
      SIDE: begin
        if (si_iv && si_ready) begin
          load      = 1'b1;
          load_byte = si_din;
          if (cnt == FS_W'(1)) begin
            if (main_len_r != '0) begin
              state_nx = MAIN;
              cnt_nx   = main_len_r;
            end else begin
              state_nx = DRAIN;
            end
          end else begin
            cnt_nx = cnt - FS_W'(1);
          end
        end
      end
      MAIN: begin
        if (md_iv && md_ready) begin
          load      = 1'b1;
          load_byte = md_din;
          if (cnt == FS_W'(1)) state_nx = DRAIN;
          else                 cnt_nx   = cnt - FS_W'(1);
        end
      end
      DRAIN: begin
        if (hs) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out        <= '0;
      d_ov         <= 1'b0;
      byte_counter <= '0;
      frame_done   <= 1'b0;
      size_err     <= 1'b0;
      hdr_r        <= '0;
      crc_r        <= '0;
      prot_r       <= 1'b0;
      side_len_r   <= '0;
      main_len_r   <= '0;
    end else begin
      frame_done <= done;
      size_err   <= reject;
      if (accept) begin
        hdr_r        <= hdr_word[23:0];
        crc_r        <= crc_word;
        prot_r       <= prot;
        side_len_r   <= side_len_in;
        main_len_r   <= frame_size - ovh_in;
        byte_counter <= '0;
      end else if (hs) begin
        byte_counter <= byte_counter + FS_W'(1);
      end
      if (load) begin
        d_out <= load_byte;
        d_ov  <= 1'b1;
      end else if (hs) begin
        d_ov <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_frame_muxer.sv
// Randomised bench for sd_frame_muxer: the expected byte stream of each frame is
// built from header/CRC/source data and compared with what the sink collects.
module tb_sd_frame_muxer;
  localparam int FS_W = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            hdr_iv, hdr_ready;
  logic [31:0]     hdr_word;
  logic [15:0]     crc_word;
  logic            prot;
  logic [1:0]      mode;
  logic [FS_W-1:0] frame_size;
  logic [7:0]      si_din, md_din, d_out;
  logic            si_iv, si_ready, md_iv, md_ready, d_ov, d_ready;
  logic [FS_W-1:0] byte_counter;
  logic            busy, frame_done, size_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sd_frame_muxer #(.SIDE_MONO(17), .SIDE_STEREO(32), .FS_W(FS_W)) dut (
    .clk(clk), .rst(rst), .hdr_iv(hdr_iv), .hdr_ready(hdr_ready),
    .hdr_word(hdr_word), .crc_word(crc_word), .prot(prot), .mode(mode),
    .frame_size(frame_size), .si_din(si_din), .si_iv(si_iv), .si_ready(si_ready),
    .md_din(md_din), .md_iv(md_iv), .md_ready(md_ready), .d_out(d_out),
    .d_ov(d_ov), .d_ready(d_ready), .byte_counter(byte_counter), .busy(busy),
    .frame_done(frame_done), .size_err(size_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_frame(input logic [31:0] hw, input logic [15:0] cw, input logic pr,
                          input logic [1:0] md, input int fs, input int si_pct,
                          input int md_pct, input int rdy_pct, input int stall_at,
                          input int rst_at);
    int side_len, ovh, main_len, pre_len, si_idx, md_idx, n_hs, stall_left, cyc, nget;
    byte unsigned side_src[$], main_src[$], exp_q[$], got_q[$];
    logic si_take, md_take, prev_stall, stalled_once;
    logic [7:0] prev_dout;
    side_len = (md == 2'b11) ? 17 : 32;
    pre_len  = pr ? 4 : 6;
    ovh      = pre_len + side_len;
    main_len = fs - ovh;

    @(negedge clk);
    hdr_iv = 1'b1; hdr_word = hw; crc_word = cw; prot = pr; mode = md;
    frame_size = FS_W'(fs); si_iv = 1'b0; md_iv = 1'b0; d_ready = 1'b1;
    #1;
    check("hdr_ready_idle", 32'(hdr_ready), 32'd1);
    check("d_ov_idle", 32'(d_ov), 32'd0);

    @(negedge clk);
    hdr_iv = 1'b0;
    hdr_word = $urandom; crc_word = 16'($urandom); prot = 1'($urandom);
    mode = 2'($urandom); frame_size = FS_W'($urandom);
    if (fs < ovh) begin
      #1;
      check("size_err_pulse", 32'(size_err), 32'd1);
      check("size_err_d_ov", 32'(d_ov), 32'd0);
      check("size_err_rdy", 32'(hdr_ready), 32'd1);
      check("size_err_busy", 32'(busy), 32'd0);
      @(negedge clk); #1;
      check("size_err_end", 32'(size_err), 32'd0);
      check("size_err_d_ov2", 32'(d_ov), 32'd0);
      return;
    end

    exp_q = {hw[31:24], hw[23:16], hw[15:8], hw[7:0]};
    if (!pr) begin exp_q.push_back(cw[15:8]); exp_q.push_back(cw[7:0]); end
    for (int i = 0; i < side_len + 4; i++) side_src.push_back(8'($urandom));
    for (int i = 0; i < main_len + 4; i++) main_src.push_back(8'($urandom));
    for (int i = 0; i < side_len; i++) exp_q.push_back(side_src[i]);
    for (int i = 0; i < main_len; i++) exp_q.push_back(main_src[i]);

    si_idx = 0; md_idx = 0; n_hs = 0; stall_left = 0;
    si_take = 1'b0; md_take = 1'b0; prev_stall = 1'b0; stalled_once = 1'b0; prev_dout = '0;
    for (cyc = 0; cyc < 20000 && n_hs < fs; cyc++) begin
      if (si_take) si_idx++;
      if (md_take) md_idx++;
      si_iv  = int'($urandom_range(99)) < si_pct;
      md_iv  = int'($urandom_range(99)) < md_pct;
      si_din = (si_idx < side_src.size()) ? side_src[si_idx] : 8'h00;
      md_din = (md_idx < main_src.size()) ? main_src[md_idx] : 8'h00;
      if (stall_at >= 0 && !stalled_once && n_hs == stall_at) begin
        stall_left = 5; stalled_once = 1'b1;
      end
      if (stall_left > 0) begin d_ready = 1'b0; stall_left--; end
      else d_ready = int'($urandom_range(99)) < rdy_pct;
      hdr_iv = ($urandom_range(9) == 0);
      if (rst_at >= 0 && n_hs == rst_at) begin
        rst = 1'b0; hdr_iv = 1'b0;
        #1;
        check("rst_d_ov", 32'(d_ov), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hdr_ready", 32'(hdr_ready), 32'd1);
        check("rst_cnt", 32'(byte_counter), 32'd0);
        check("rst_md_ready", 32'(md_ready), 32'd0);
        check("rst_si_ready", 32'(si_ready), 32'd0);
        @(negedge clk); @(negedge clk);
        #1 check("rst_hold_d_ov", 32'(d_ov), 32'd0);
        rst = 1'b1;
        return;
      end
      #1;
      if (cyc == 0) begin
        check("first_d_ov", 32'(d_ov), 32'd1);
        check("first_byte", 32'(d_out), 32'(hw[31:24]));
      end
      check("busy", 32'(busy), 32'd1);
      check("hdr_ready_busy", 32'(hdr_ready), 32'd0);
      check("done_early", 32'(frame_done), 32'd0);
      check("byte_counter", 32'(byte_counter), 32'(n_hs));
      check("rdy_excl", 32'(si_ready && md_ready), 32'd0);
      check("si_early", 32'(si_ready && (n_hs + int'(d_ov)) < pre_len), 32'd0);
      check("si_extra", 32'(si_ready && si_idx >= side_len), 32'd0);
      check("md_gate", 32'(md_ready && (si_idx < side_len || md_idx >= main_len)), 32'd0);
      if (d_ov && !d_ready) begin
        check("stall_si", 32'(si_ready), 32'd0);
        check("stall_md", 32'(md_ready), 32'd0);
      end
      if (prev_stall) begin
        check("hold_d_ov", 32'(d_ov), 32'd1);
        check("hold_d_out", 32'(d_out), 32'(prev_dout));
      end
      si_take = si_iv && si_ready;
      md_take = md_iv && md_ready;
      if (d_ov && d_ready) begin got_q.push_back(d_out); n_hs++; end
      prev_stall = d_ov && !d_ready;
      prev_dout  = d_out;
      @(negedge clk);
    end
    check("frame_timeout", 32'(n_hs >= fs), 32'd1);
    if (si_take) si_idx++;
    if (md_take) md_idx++;
    hdr_iv = 1'b0; si_iv = 1'b0; md_iv = 1'b0; d_ready = 1'($urandom);
    #1;
    check("frame_done", 32'(frame_done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_hdr_ready", 32'(hdr_ready), 32'd1);
    check("done_count", 32'(byte_counter), 32'(fs));
    check("done_d_ov", 32'(d_ov), 32'd0);
    check("side_taken", 32'(si_idx), 32'(side_len));
    check("main_taken", 32'(md_idx), 32'(main_len));
    @(negedge clk); #1;
    check("done_pulse_end", 32'(frame_done), 32'd0);
    check("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
    nget = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nget; i++)
      check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    if (n_hs < fs) begin
      rst = 1'b0; @(negedge clk); rst = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0; hdr_iv = 1'b0; hdr_word = '0; crc_word = '0; prot = 1'b0; mode = '0;
    frame_size = '0; si_din = '0; si_iv = 1'b0; md_din = '0; md_iv = 1'b0; d_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state_d_ov", 32'(d_ov), 32'd0);
    check("rst_state_d_out", 32'(d_out), 32'd0);
    check("rst_state_cnt", 32'(byte_counter), 32'd0);
    check("rst_state_busy", 32'(busy), 32'd0);
    check("rst_state_hdr_ready", 32'(hdr_ready), 32'd1);
    check("rst_state_done", 32'(frame_done), 32'd0);
    check("rst_state_size_err", 32'(size_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_frame(32'hFFFB9264, 16'h0000, 1'b1, 2'b01, 418, 100, 100, 100, -1, -1);
    do_frame(32'hFFFA1234, 16'hA53C, 1'b0, 2'b11, 48, 100, 100, 100, -1, -1);
    do_frame(32'hFFF35678, 16'h1F2E, 1'b0, 2'b00, 100, 100, 100, 100, 16, -1);
    do_frame(32'hFFFB0000, 16'h5555, 1'b0, 2'b00, 30, 100, 100, 100, -1, -1);
    do_frame(32'hFFFBC0DE, 16'h0000, 1'b1, 2'b11, 21, 100, 100, 100, -1, -1);
    do_frame(32'hFFFBC0DE, 16'h0000, 1'b1, 2'b11, 20, 100, 100, 100, -1, -1);
    do_frame(32'hFFFB9264, 16'h0000, 1'b1, 2'b01, 418, 100, 100, 100, -1, 136);
    do_frame(32'hFFFB9264, 16'h0000, 1'b1, 2'b01, 418, 100, 100, 100, -1, -1);

    for (int n = 0; n < 8; n++) begin
      logic       rp;
      logic [1:0] rm;
      int         rovh;
      rp   = 1'($urandom);
      rm   = 2'($urandom);
      rovh = (rp ? 4 : 6) + ((rm == 2'b11) ? 17 : 32);
      do_frame($urandom, 16'($urandom), rp, rm, rovh - 3 + int'($urandom_range(80)),
               int'($urandom_range(100, 40)), int'($urandom_range(100, 40)),
               int'($urandom_range(100, 40)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_frame_muxer.md
Name: sd_frame_muxer

Overview:
- Transmit-side counterpart of sd_plexer: assembles one MP3 frame into a byte stream.
- Emits, in order: 4 header bytes, 2 CRC16 bytes (only when protected), side-info bytes, then main-data bytes.
- Downstream is an SD write path or loopback into sd_plexer, using a registered valid/ready byte interface.

Parameters:
- SIDE_MONO, 17, side-info byte count when mode==2'b11.
- SIDE_STEREO, 32, side-info byte count for all other modes.
- FS_W, 11, width of frame_size and byte_counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: asynchronous, active-low.
- hdr_iv  input  1  frame request; accepted only when hdr_ready=1.
- hdr_ready  output  1  high in IDLE only.
- hdr_word  input  32  frame header; sent MSB byte first.
- crc_word  input  16  CRC16; sent MSB byte first when prot=0.
- prot  input  1  1 = no CRC bytes sent.
- mode  input  2  channel mode; selects side-info length.
- frame_size  input  FS_W  total frame bytes, header included.
- si_din  input  8  side-info byte.
- si_iv  input  1  side-info byte valid.
- si_ready  output  1  side-info byte accepted when si_iv & si_ready.
- md_din  input  8  main-data byte.
- md_iv  input  1  main-data byte valid.
- md_ready  output  1  main-data byte accepted when md_iv & md_ready.
- d_out  output  8  output byte.
- d_ov  output  1  d_out valid.
- d_ready  input  1  downstream accepts when d_ov & d_ready.
- byte_counter  output  FS_W  bytes handed off in the current frame.
- busy  output  1  state != IDLE.
- frame_done  output  1  one-cycle pulse on the final byte handshake.
- size_err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; d_out=0, d_ov=0, byte_counter=0.
  - frame_done=0, size_err=0, busy=0, hdr_ready=1.
  - Internal latches cleared.
  - Reset mid-frame abandons the frame with no further bytes; the next request after release starts clean.
- Request acceptance (hdr_iv & hdr_ready, cycle N):
  - Latch hdr_word, crc_word, prot, frame_size.
  - side_len = SIDE_MONO if mode==3, else SIDE_STEREO.
  - ovh = 4 + (prot ? 0 : 2) + side_len.
  - main_len = frame_size - ovh, computed at FS_W bits.
- Size check: if frame_size < ovh:
  - size_err pulses at N+1.
  - State stays IDLE; d_ov never asserts.
- States: IDLE -> HDR(4) -> CRC(2, skipped if prot) -> SIDE(side_len) -> MAIN(main_len, skipped if 0) -> IDLE.
  - Each state holds a down-counter; it advances when its last byte is loaded into the output register.
- Output register load rule: a new byte loads when (!d_ov | d_ready) and a byte is available.
  - HDR and CRC bytes are always available; the first header byte shows d_ov=1 at N+1.
  - SIDE: si_ready = (state==SIDE) & (!d_ov | d_ready); the byte loads on si_iv & si_ready.
  - MAIN: md_ready uses the same rule with state==MAIN.
- si_ready and md_ready are combinational on d_ready and never both high.
- Backpressure: while d_ov=1 & d_ready=0, d_out is held stable and no source is accepted.
- No byte may be dropped or duplicated.
- Bubbles: if the source is invalid when a load is allowed, d_ov drops to 0 on the next cycle after the pending byte is taken.
- byte_counter:
  - Increments on each d_ov & d_ready handshake.
  - Clears to 0 on acceptance of a new request.
  - Equals frame_size after the last handshake.
- frame_done pulses in the cycle after the handshake of byte frame_size.
  - busy stays high through that handshake, and hdr_ready returns the same cycle frame_done is high.
- hdr_iv while busy is ignored; mid-frame input changes are ignored because fields are latched.

Test Plan:
- hdr_word=0xFFFB9264, mode=01, prot=1, frame_size=418, sources always valid, d_ready=1 -> d_out = FF FB 92 64, then 32 side bytes, then 382 main bytes; frame_done after the 418th byte; byte_counter=418; output feeds sd_plexer+header with matching header_ov decode.
- prot=0, mode=11, frame_size=48, crc_word=0xA53C -> sequence header(4), A5, 3C, 17 side, 25 main; md_ready first high only after the 17th side byte is taken.
- d_ready low for 5 cycles during SIDE byte 10 -> d_out held constant for 5 cycles; si_ready=0; the side sequence at the sink has no gap or duplication.
- prot=0, mode=00, frame_size=30 (ovh=38) -> size_err pulse; d_ov=0 throughout; hdr_ready=1 the next cycle.
- prot=1, mode=11, frame_size=21 -> MAIN skipped; md_ready never asserted; frame_done after the 21st byte.
- rst low during MAIN byte 100 -> d_ov=0 and busy=0 immediately (asynchronous); a new 418-byte frame after release is emitted exactly as in the first scenario.
